uart_frame_check: RTL

Parametrised receive-frame checker for the UART RX path. It replaces the single stop-bit check with a full check of start, data, parity and stop bits. Mid-bit samples come from the RX baud/oversampling stage. Per frame it outputs the assembled data word, one valid pulse and error flags.

---
 rtl/uart_frame_check.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_frame_check.sv
// UART RX frame checker: validates start, data, parity and stop bits from mid-bit strobes.
// Optional break detection is compiled in when UART_BREAK_DETECT_EN is defined.
module uart_frame_check #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_bit,
    input  logic                 sample_stb,
    input  logic                 frame_start,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 start_err,
    output logic                 busy,
    output logic                 break_det
);

    localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_MODE != 0);
`ifdef UART_BREAK_DETECT_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $fatal(1, "uart_frame_check: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $fatal(1, "uart_frame_check: STOP_BITS must be 1 or 2");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
            $fatal(1, "uart_frame_check: PARITY_MODE must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 par_zero;
    logic                 stop0_low;
    logic                 stop_bad;

    // The completion decision is formed from the final stop sample as it arrives.
    logic last_stop;
    logic frame_bad;
    logic first_stop_low;
    logic is_break;
    logic data_parity;

    assign data_parity    = ^shreg;
    assign last_stop      = (state == STOP) && sample_stb && (cnt == LAST_STOP);
    assign frame_bad      = stop_bad | ~rx_bit;
    assign first_stop_low = (cnt == '0) ? ~rx_bit : stop0_low;
    assign is_break       = BREAK_EN && (shreg == '0) && par_zero && first_stop_low;
    assign busy           = (state != IDLE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            par_zero   <= 1'b0;
            stop0_low  <= 1'b0;
            stop_bad   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            start_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            start_err  <= 1'b0;
            break_det  <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= START;
                    end
                end

                START: begin
                    if (sample_stb) begin
                        if (rx_bit) begin
                            start_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state     <= DATA;
                            cnt       <= '0;
                            par_bad   <= 1'b0;
                            par_zero  <= 1'b1;
                            stop0_low <= 1'b0;
                            stop_bad  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (sample_stb) begin
                        shreg <= {rx_bit, shreg[DATA_BITS-1:1]};
                        if (cnt == LAST_DATA) begin
                            cnt   <= '0;
                            state <= HAS_PARITY ? PARITY : STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (sample_stb) begin
                        // Even parity expects the data XOR; odd expects its complement.
                        par_bad  <= (PARITY_MODE == 2) ? (rx_bit != data_parity)
                                                       : (rx_bit == data_parity);
                        par_zero <= ~rx_bit;
                        cnt      <= '0;
                        state    <= STOP;
                    end
                end

                STOP: begin
                    if (sample_stb) begin
                        if (cnt == '0) begin
                            stop0_low <= ~rx_bit;
                        end
                        if (!rx_bit) begin
                            stop_bad <= 1'b1;
                        end
                        if (last_stop) begin
                            cnt   <= '0;
                            state <= IDLE;
                            if (is_break) begin
                                break_det <= 1'b1;
                                frame_err <= 1'b1;
                            end else begin
                                data_valid <= 1'b1;
                                data_out   <= shreg;
                                parity_err <= HAS_PARITY && par_bad;
                                frame_err  <= frame_bad;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
